l1d_data_ram_ctrl: RTL and testbench

L1D_DATA_RAM_CTRL -- requirements
Module: l1d_data_ram_ctrl

---
 rtl/l1d_data_ram_ctrl.sv | 148 ++++++++++++++
 tb/tb_l1d_data_ram_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_data_ram_ctrl.sv
// l1d_data_ram_ctrl
//   Front end of the L1D data SRAM. Accepts pipe requests, strobes the SRAM
//   combinationally in the accept cycle, and returns read data through a
//   2-entry in-order return FIFO. Each FIFO entry is routed either to the evict
//   port or to the upstream response port, according to its downstream tag.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   pipe_*              : request from the data-pipe arbiter (valid/ready)
//   ram_*               : SRAM strobe/address/write data; ram_rdata arrives
//                         one cycle after a read strobe
//   evict_rd_*          : evict read data (valid/ready)
//   rd_resp_*           : upstream read response (valid/ready)
module l1d_data_ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256,
    parameter int BE_W   = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_vld,
    output logic              pipe_rdy,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic              pipe_rw_type,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic [BE_W-1:0]   pipe_be,
    input  logic              pipe_downstream,
    input  logic [ID_W-1:0]   pipe_id,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_wbe,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              evict_rd_vld,
    input  logic              evict_rd_rdy,
    output logic [DATA_W-1:0] evict_rd_data,
    output logic [ID_W-1:0]   evict_rd_id,
    output logic              rd_resp_vld,
    input  logic              rd_resp_rdy,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic [ID_W-1:0]   rd_resp_id
);

    // Read in flight: tag of the read strobed last cycle.
    logic              infl_q, infl_d;
    logic              infl_ds_q, infl_ds_d;
    logic [ID_W-1:0]   infl_id_q, infl_id_d;

    // Return FIFO storage and pointers.
    logic [DATA_W-1:0] fdata_q [2];
    logic [DATA_W-1:0] fdata_d [2];
    logic              fds_q   [2];
    logic              fds_d   [2];
    logic [ID_W-1:0]   fid_q   [2];
    logic [ID_W-1:0]   fid_d   [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        fcnt_q, fcnt_d;

    logic              head_vld;
    logic              head_ds;
    logic              pop;
    logic              push;
    logic [1:0]        cnt;
    logic              rd_room;
    logic              acc;
    logic              acc_rd;

    always_comb begin
        head_vld = (fcnt_q != 2'd0);
        head_ds  = fds_q[rd_ptr_q];

        // The head goes to exactly one port; a stalled head blocks both.
        evict_rd_vld  = head_vld && head_ds;
        rd_resp_vld   = head_vld && !head_ds;
        evict_rd_data = fdata_q[rd_ptr_q];
        evict_rd_id   = fid_q[rd_ptr_q];
        rd_resp_data  = fdata_q[rd_ptr_q];
        rd_resp_id    = fid_q[rd_ptr_q];
        pop = (evict_rd_vld && evict_rd_rdy) || (rd_resp_vld && rd_resp_rdy);

        // Credits cover buffered entries plus the read in flight. A pop this
        // cycle frees a slot in time for a read accepted now, because its data
        // only enters the FIFO two edges later. No underflow: pop implies
        // fcnt_q >= 1.
        cnt     = fcnt_q + {1'b0, infl_q};
        rd_room = ((cnt - {1'b0, pop}) < 2'd2);

        pipe_rdy = !pipe_rw_type || rd_room;
        acc      = pipe_vld && pipe_rdy;
        acc_rd   = acc && pipe_rw_type;

        ram_en    = acc;
        ram_we    = acc && !pipe_rw_type;
        ram_addr  = pipe_addr;
        ram_wdata = pipe_wdata;
        ram_wbe   = pipe_be;

        infl_d    = acc_rd;
        infl_ds_d = acc_rd ? pipe_downstream : infl_ds_q;
        infl_id_d = acc_rd ? pipe_id : infl_id_q;

        // SRAM data is valid the cycle after the strobe; capture it then.
        push    = infl_q;
        fdata_d = fdata_q;
        fds_d   = fds_q;
        fid_d   = fid_q;
        if (push) begin
            fdata_d[wr_ptr_q] = ram_rdata;
            fds_d[wr_ptr_q]   = infl_ds_q;
            fid_d[wr_ptr_q]   = infl_id_q;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        fcnt_d   = fcnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q    <= 1'b0;
            infl_ds_q <= 1'b0;
            infl_id_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fcnt_q    <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                fds_q[i]   <= 1'b0;
                fid_q[i]   <= '0;
            end
        end else begin
            infl_q    <= infl_d;
            infl_ds_q <= infl_ds_d;
            infl_id_q <= infl_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fcnt_q    <= fcnt_d;
            for (int unsigned i = 0; i < 2; i++) begin
                fdata_q[i] <= fdata_d[i];
                fds_q[i]   <= fds_d[i];
                fid_q[i]   <= fid_d[i];
            end
        end
    end

endmodule

// File: tb/tb_l1d_data_ram_ctrl.sv
// Testbench for l1d_data_ram_ctrl: directed scenarios with literal
// expectations plus a long randomized run, checked every cycle against a
// transaction-level model (memory array + queue of outstanding reads).
module tb_l1d_data_ram_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         pipe_vld, pipe_rdy;
    logic [7:0]   pipe_addr;
    logic         pipe_rw_type;
    logic [255:0] pipe_wdata;
    logic [31:0]  pipe_be;
    logic         pipe_downstream;
    logic [3:0]   pipe_id;
    logic         ram_en, ram_we;
    logic [7:0]   ram_addr;
    logic [255:0] ram_wdata;
    logic [31:0]  ram_wbe;
    logic [255:0] ram_rdata = '0;
    logic         evict_rd_vld, evict_rd_rdy;
    logic [255:0] evict_rd_data;
    logic [3:0]   evict_rd_id;
    logic         rd_resp_vld, rd_resp_rdy;
    logic [255:0] rd_resp_data;
    logic [3:0]   rd_resp_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1d_data_ram_ctrl #(.ADDR_W(8), .DATA_W(256), .BE_W(32), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_vld(pipe_vld), .pipe_rdy(pipe_rdy), .pipe_addr(pipe_addr),
        .pipe_rw_type(pipe_rw_type), .pipe_wdata(pipe_wdata), .pipe_be(pipe_be),
        .pipe_downstream(pipe_downstream), .pipe_id(pipe_id),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wbe(ram_wbe), .ram_rdata(ram_rdata),
        .evict_rd_vld(evict_rd_vld), .evict_rd_rdy(evict_rd_rdy),
        .evict_rd_data(evict_rd_data), .evict_rd_id(evict_rd_id),
        .rd_resp_vld(rd_resp_vld), .rd_resp_rdy(rd_resp_rdy),
        .rd_resp_data(rd_resp_data), .rd_resp_id(rd_resp_id)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // SRAM: read data valid one cycle after the strobe, junk otherwise.
    logic [255:0] sram [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int b = 0; b < 32; b++)
                if (ram_wbe[b]) sram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        if (ram_en && !ram_we) ram_rdata <= sram[ram_addr];
        else                   ram_rdata <= rand256();
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: contents the SRAM must hold, and every accepted read
    // not yet handed out, in acceptance order. A read becomes visible two
    // cycles after its accept cycle and leaves only when its port is ready.
    typedef struct {
        logic         ds;
        logic [3:0]   id;
        logic [255:0] data;
        int           cyc;
    } resp_t;
    resp_t        q[$];
    logic [255:0] mmem [256] = '{default: '0};
    int           cyc = 0;

    always @(negedge clk) begin
        bit hv, hds, pop, exp_rdy, exp_acc;
        if (rst) begin
            q.delete();
            chk("rst_evict_vld", evict_rd_vld, 0);
            chk("rst_resp_vld", rd_resp_vld, 0);
            chk("rst_pipe_rdy", pipe_rdy, 1);
        end else begin
            hv  = 0;
            hds = 0;
            if (q.size() > 0) begin
                hv  = (cyc >= q[0].cyc + 2);
                hds = q[0].ds;
            end
            pop     = hv && (hds ? evict_rd_rdy : rd_resp_rdy);
            exp_rdy = !pipe_rw_type || ((q.size() - int'(pop)) < 2);
            exp_acc = pipe_vld && exp_rdy;
            chk("pipe_rdy", pipe_rdy, exp_rdy);
            chk("ram_en", ram_en, exp_acc);
            if (exp_acc) begin
                chk("ram_we", ram_we, !pipe_rw_type);
                chk("ram_addr", ram_addr, pipe_addr);
                if (!pipe_rw_type) begin
                    chk("ram_wdata", ram_wdata, pipe_wdata);
                    chk("ram_wbe", ram_wbe, pipe_be);
                end
            end
            chk("evict_rd_vld", evict_rd_vld, hv && hds);
            chk("rd_resp_vld", rd_resp_vld, hv && !hds);
            if (hv && hds) begin
                chk("evict_rd_data", evict_rd_data, q[0].data);
                chk("evict_rd_id", evict_rd_id, q[0].id);
            end
            if (hv && !hds) begin
                chk("rd_resp_data", rd_resp_data, q[0].data);
                chk("rd_resp_id", rd_resp_id, q[0].id);
            end
            if (pop) void'(q.pop_front());
            if (exp_acc) begin
                if (!pipe_rw_type) begin
                    for (int b = 0; b < 32; b++)
                        if (pipe_be[b]) mmem[pipe_addr][b*8 +: 8] = pipe_wdata[b*8 +: 8];
                end else begin
                    q.push_back('{ds: pipe_downstream, id: pipe_id,
                                  data: mmem[pipe_addr], cyc: cyc});
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_vld = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [3:0] id, input logic ds);
        pipe_vld = 1; pipe_rw_type = 1; pipe_addr = a; pipe_id = id;
        pipe_downstream = ds; pipe_wdata = rand256(); pipe_be = $urandom;
    endtask

    task automatic wr(input logic [7:0] a, input logic [255:0] d, input logic [31:0] be);
        pipe_vld = 1; pipe_rw_type = 0; pipe_addr = a; pipe_wdata = d;
        pipe_be = be; pipe_downstream = 0; pipe_id = 0;
    endtask

    logic [255:0] a5;

    initial begin
        a5 = {32{8'hA5}};
        rst = 1; pipe_vld = 0; pipe_rw_type = 0; pipe_addr = 0; pipe_wdata = 0;
        pipe_be = 0; pipe_downstream = 0; pipe_id = 0;
        evict_rd_rdy = 0; rd_resp_rdy = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pipe_rdy", pipe_rdy, 1);
        chk("reset_ram_en", ram_en, 0);
        chk("reset_evict_vld", evict_rd_vld, 0);
        chk("reset_resp_vld", rd_resp_vld, 0);
        rst = 0;
        step();

        // Write 0x10 with all bytes enabled
        wr(8'h10, a5, '1);
        #1;
        chk("wr_ram_en", ram_en, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 8'h10);
        chk("wr_no_resp", rd_resp_vld | evict_rd_vld, 0);
        step();

        // Read it back upstream: visible two cycles after accept
        rd(8'h10, 4'd3, 1'b0);
        rd_resp_rdy = 1;
        #1;
        chk("rd_accept", pipe_rdy, 1);
        step();
        idle();
        #1;
        chk("rd_lat1_vld", rd_resp_vld, 0);
        step();
        chk("rd_lat2_vld", rd_resp_vld, 1);
        chk("rd_lat2_data", rd_resp_data, a5);
        chk("rd_lat2_id", rd_resp_id, 4'd3);
        step();

        // Four back-to-back reads stream without stalls
        for (int c = 0; c < 6; c++) begin
            if (c < 4) rd(c[7:0], c[3:0], 1'b0); else idle();
            #1;
            if (c < 4) chk("b2b_pipe_rdy", pipe_rdy, 1);
            if (c >= 2) begin
                chk("b2b_vld", rd_resp_vld, 1);
                chk("b2b_id", rd_resp_id, 4'(c - 2));
            end
            step();
        end

        // Backpressure: two credits, third read waits for the first pop
        rd_resp_rdy = 0;
        rd(8'd0, 4'd8, 1'b0);  #1; chk("bp_acc0", pipe_rdy, 1); step();
        rd(8'd1, 4'd9, 1'b0);  #1; chk("bp_acc1", pipe_rdy, 1); step();
        rd(8'd2, 4'd10, 1'b0); #1; chk("bp_stall2", pipe_rdy, 0); step();
        #1; chk("bp_stall3", pipe_rdy, 0);
        rd_resp_rdy = 1;
        #1;
        chk("bp_release_rdy", pipe_rdy, 1);
        chk("bp_head_id", rd_resp_id, 4'd8);
        step();
        idle();
        repeat (4) step();

        // A stalled evict head blocks the upstream response behind it
        evict_rd_rdy = 0;
        rd(8'd3, 4'd5, 1'b1); step();
        rd(8'd4, 4'd6, 1'b0); step();
        idle();
        for (int c = 2; c < 5; c++) begin
            #1;
            chk("hol_resp_blocked", rd_resp_vld, 0);
            chk("hol_evict_vld", evict_rd_vld, 1);
            step();
        end
        evict_rd_rdy = 1;
        #1;
        chk("hol_evict_id", evict_rd_id, 4'd5);
        step();
        evict_rd_rdy = 0;
        #1;
        chk("hol_resp_vld", rd_resp_vld, 1);
        chk("hol_resp_id", rd_resp_id, 4'd6);
        step();

        // Reset with the FIFO full discards everything
        rd_resp_rdy = 0;
        rd(8'd5, 4'd1, 1'b0); step();
        rd(8'd6, 4'd2, 1'b1); step();
        idle();
        step();
        #1;
        chk("full_head_vld", rd_resp_vld, 1);
        rst = 1;
        #1;
        chk("async_rst_resp", rd_resp_vld, 0);
        chk("async_rst_evict", evict_rd_vld, 0);
        step(); step();
        rst = 0;
        #1;
        chk("post_rst_rdy", pipe_rdy, 1);
        rd_resp_rdy = 1; evict_rd_rdy = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("no_stale", rd_resp_vld | evict_rd_vld, 0);
            step();
        end

        // Randomized traffic, occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle();
                rst = 1;
                step(); step();
                rst = 0;
            end
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1)
                    rd(8'($urandom_range(0, 7)), 4'($urandom), 1'($urandom));
                else
                    wr(8'($urandom_range(0, 7)), rand256(), $urandom);
            end else begin
                idle();
                pipe_rw_type = 1'($urandom);
            end
            rd_resp_rdy  = ($urandom_range(0, 9) < 7);
            evict_rd_rdy = ($urandom_range(0, 9) < 7);
            step();
        end
        idle();
        rd_resp_rdy = 1; evict_rd_rdy = 1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
